// File: rtl/power_aes_unwind_if.sv
// Host-side handshake bundle for power_aes_unwind: input word stream, decoded
// output stream and status.
interface power_aes_unwind_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic [15:0] words_done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, words_done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, words_done
    );
endinterface

// File: rtl/power_aes_unwind.sv
// Forward-S-box unwinder: applies ROUNDS rounds of w = S(w) ^ KEY, one per cycle,
// to undo the inverse-S-box chain of the power target. Contains its own S-box LUT.
module aes_sbox_lut (
    input  logic [7:0] din,
    input  logic       dec,
    output logic [7:0] dout
);
    localparam logic [0:255][7:0] FWD = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Inverse direction is derived from the forward table by search rather than a second table.
    function automatic logic [7:0] inv_lookup(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 256; i++) begin
            if (FWD[i[7:0]] == v) r = i[7:0];
        end
        return r;
    endfunction

    always_comb begin
        dout = dec ? inv_lookup(din) : FWD[din];
    end
endmodule

module power_aes_unwind #(
    parameter int unsigned ROUNDS = 4,
    parameter logic [31:0] KEY    = 32'hDEADC0DE
) (
    input logic                  ICE_CLK,
    input logic                  resetn,
    power_aes_unwind_if.slave    io
);
    if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
        $error("power_aes_unwind: ROUNDS must be in 1..15");
    end

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    logic [1:0]  state;
    logic [31:0] work_reg;
    logic [3:0]  round_cnt;
    logic [15:0] done_cnt;
    logic [31:0] sbox_out;
    logic [31:0] round_out;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox_lut u_sbox (
            .din  (work_reg[8*b +: 8]),
            .dec  (1'b0),
            .dout (sbox_out[8*b +: 8])
        );
    end

    assign round_out = sbox_out ^ KEY;

    always_ff @(posedge ICE_CLK) begin
        if (!resetn) begin
            state     <= IDLE;
            work_reg  <= '0;
            round_cnt <= '0;
            done_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        work_reg  <= io.in_data;
                        round_cnt <= '0;
                        state     <= ROUND;
                    end
                end
                ROUND: begin
                    work_reg  <= round_out;
                    round_cnt <= round_cnt + 4'd1;
                    if (round_cnt == LAST_ROUND) state <= DONE;
                end
                DONE: begin
                    // Handoff edge returns to IDLE only; the next word is taken a cycle later.
                    if (io.out_ready) begin
                        if (done_cnt != '1) done_cnt <= done_cnt + 16'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        io.in_ready   = (state == IDLE);
        io.out_valid  = (state == DONE);
        io.busy       = (state != IDLE);
        io.out_data   = work_reg;
        io.words_done = done_cnt;
    end
endmodule

// File: tb/tb_power_aes_unwind.sv
// Directed bench for power_aes_unwind: known vectors, LFSR round trip through an
// independent GF(2^8) S-box model, backpressure, reset abort and counter saturation.
module tb_power_aes_unwind;
    localparam logic [31:0] DKEY = 32'hDEADC0DE;

    logic ICE_CLK = 1'b0;
    logic resetn  = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    always #5 ICE_CLK = ~ICE_CLK;

    power_aes_unwind_if m ();
    power_aes_unwind_if a1 ();
    power_aes_unwind_if a2 ();
    power_aes_unwind_if a3 ();

    power_aes_unwind #(.ROUNDS(4)) dut (.ICE_CLK(ICE_CLK), .resetn(resetn), .io(m));
    power_aes_unwind #(.ROUNDS(1)) dut_a1 (.ICE_CLK(ICE_CLK), .resetn(resetn), .io(a1));
    power_aes_unwind #(.ROUNDS(2), .KEY(32'h0)) dut_a2 (.ICE_CLK(ICE_CLK), .resetn(resetn), .io(a2));
    power_aes_unwind #(.ROUNDS(1), .KEY(32'h0)) dut_a3 (.ICE_CLK(ICE_CLK), .resetn(resetn), .io(a3));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ICE_CLK);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] encode(input logic [31:0] p);
        logic [31:0] w;
        logic [31:0] t;
        w = p;
        for (int r = 0; r < 4; r++) begin
            t = w ^ DKEY;
            for (int b = 0; b < 4; b++) w[8*b +: 8] = isb[t[8*b +: 8]];
        end
        return w;
    endfunction

    // Offers one encoded word to the main DUT and waits (bounded) for the result.
    task automatic send_and_wait(input logic [31:0] plain, output int lat);
        int n;
        n = 0;
        m.in_data  = encode(plain);
        m.in_valid = 1'b1;
        while (!m.in_ready && n < 50) begin step(); n++; end
        step();
        m.in_valid = 1'b0;
        lat = 0;
        while (!m.out_valid && lat < 50) begin step(); lat++; end
    endtask

    task automatic handoff();
        m.out_ready = 1'b1;
        step();
        m.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] lfsr;
        logic [31:0] held;
        int lat;

        build_sbox();
        m.in_valid = 0;  m.in_data = '0;  m.out_ready = 0;
        a1.in_valid = 0; a1.in_data = '0; a1.out_ready = 0;
        a2.in_valid = 0; a2.in_data = '0; a2.out_ready = 0;
        a3.in_valid = 0; a3.in_data = '0; a3.out_ready = 0;
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;

        check_val("rst_in_ready", 32'(m.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(m.out_valid), 32'd0);
        check_val("rst_busy", 32'(m.busy), 32'd0);
        check_val("rst_out_data", m.out_data, 32'h0);
        check_val("rst_words_done", 32'(m.words_done), 32'd0);

        // Known vectors on the auxiliary instances, accepted on the same edge
        a1.in_data = 32'h0; a2.in_data = 32'h0; a3.in_data = 32'h52525252;
        a1.in_valid = 1; a2.in_valid = 1; a3.in_valid = 1;
        step();
        a1.in_valid = 0; a2.in_valid = 0; a3.in_valid = 0;
        check_val("a1_busy", 32'(a1.busy), 32'd1);
        check_val("a1_in_ready", 32'(a1.in_ready), 32'd0);
        step();
        check_val("a1_out_valid", 32'(a1.out_valid), 32'd1);
        check_val("a1_out_data", a1.out_data, 32'hBDCEA3BD);
        check_val("a3_out_data", a3.out_data, 32'h0);
        check_val("a2_not_yet", 32'(a2.out_valid), 32'd0);
        step();
        check_val("a2_out_valid", 32'(a2.out_valid), 32'd1);
        check_val("a2_out_data", a2.out_data, 32'hFBFBFBFB);
        check_val("a1_hold", a1.out_data, 32'hBDCEA3BD);
        a1.out_ready = 1; a2.out_ready = 1; a3.out_ready = 1;
        step();
        a1.out_ready = 0; a2.out_ready = 0; a3.out_ready = 0;
        check_val("a1_words_done", 32'(a1.words_done), 32'd1);
        check_val("a2_words_done", 32'(a2.words_done), 32'd1);
        check_val("a1_idle_after", 32'(a1.out_valid), 32'd0);
        check_val("a1_busy_after", 32'(a1.busy), 32'd0);

        // Round trip of LFSR words through the independent encoder
        lfsr = 32'hACE1ACE1;
        for (int i = 0; i < 1000; i++) begin
            send_and_wait(lfsr, lat);
            if (i < 4) check_val("latency", 32'(lat), 32'd4);
            check_val("roundtrip", m.out_data, lfsr);
            handoff();
            lfsr = lfsr[0] ? ((lfsr >> 1) ^ 32'h80200003) : (lfsr >> 1);
        end
        check_val("words_1000", 32'(m.words_done), 32'd1000);

        // Backpressure while upstream keeps offering changing data
        held = 32'h12345678;
        send_and_wait(held, lat);
        for (int c = 0; c < 20; c++) begin
            m.in_valid = 1'b1;
            m.in_data  = 32'hA5A50000 + 32'(c);
            step();
            check_val("bp_out_data", m.out_data, held);
            check_val("bp_in_ready", 32'(m.in_ready), 32'd0);
        end
        handoff();
        check_val("bp_no_accept", 32'(m.busy), 32'd0);
        check_val("bp_in_ready_after", 32'(m.in_ready), 32'd1);
        check_val("bp_words", 32'(m.words_done), 32'd1001);
        m.in_valid = 1'b0;
        step();

        // Reset during the second of four rounds
        m.in_data = encode(32'hCAFEF00D);
        m.in_valid = 1'b1;
        step();
        m.in_valid = 1'b0;
        step();
        resetn = 1'b0;
        step();
        check_val("mid_rst_in_ready", 32'(m.in_ready), 32'd1);
        check_val("mid_rst_out_valid", 32'(m.out_valid), 32'd0);
        check_val("mid_rst_out_data", m.out_data, 32'h0);
        check_val("mid_rst_words", 32'(m.words_done), 32'd0);
        resetn = 1'b1;
        for (int c = 0; c < 8; c++) step();
        check_val("mid_rst_no_emit", 32'(m.out_valid), 32'd0);
        check_val("mid_rst_words_after", 32'(m.words_done), 32'd0);

        // Counter saturation via preload
        force dut.done_cnt = 16'hFFFE;
        step();
        release dut.done_cnt;
        send_and_wait(32'h0BADBEEF, lat);
        check_val("sat_data0", m.out_data, 32'h0BADBEEF);
        handoff();
        check_val("sat_reach", 32'(m.words_done), 32'h0000FFFF);
        step();
        send_and_wait(32'h76543210, lat);
        check_val("sat_data1", m.out_data, 32'h76543210);
        handoff();
        check_val("sat_hold", 32'(m.words_done), 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/power_aes_unwind.md
# power_aes_unwind

Forward-S-box decoder that undoes the iterated inverse-S-box chain of the 4-S-box power target. Each captured 32-bit text word was produced by repeated rounds of inverse S-box applied to (word ^ KEY). This block applies the inverse operation, forward S-box then XOR KEY, for the same number of rounds, one round per cycle, and recovers the original LFSR plaintext. It sits between the capture/readout path and the host-facing interface, uses a valid/ready handshake on both sides, and drives a 16-bit completed-word counter for bench and board sanity checks.

## Interface
- ROUNDS, 4, number of forward rounds per word; legal range 1..15.
- KEY, 32'hDEADC0DE, 32-bit XOR mask applied after each round's S-box layer.
- ICE_CLK  in  1  clock, all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data is offered.
- in_ready  out  1  block can accept a word.
- in_data  in  32  captured text word to decode.
- out_valid  out  1  out_data holds a decoded word.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  32  recovered plaintext.
- busy  out  1  high whenever the state is not IDLE.
- words_done  out  16  count of words handed off downstream; saturates at 16'hFFFF.

## Operation
- Datapath: four aes_sbox_lut instances with dec tied to 0, one per byte: [7:0], [15:8], [23:16], [31:24]. Round function: f(w) = S(w) ^ KEY, applied bytewise with no byte movement.
- Registers: work_reg[31:0], round_cnt[3:0], state[1:0], words_done[15:0].
- States:
  - IDLE: in_ready=1.
    - On in_valid: work_reg<=in_data, round_cnt<=0, go to ROUND.
  - ROUND: in_ready=0.
    - Each cycle: work_reg<=f(work_reg), round_cnt<=round_cnt+1.
    - When round_cnt==ROUNDS-1, that update is the final one; go to DONE.
  - DONE: out_valid=1, out_data=work_reg.
    - On out_ready: words_done<=sat(words_done+1), go to IDLE.
    - Without out_ready: hold, with out_data stable.
- out_data equals work_reg in every state. It is only meaningful while out_valid is high.
- in_data is ignored in ROUND and DONE. The upstream side must hold in_valid until in_ready is seen.
- The block accepts no new word in the cycle it completes the DONE handshake. A new word can be accepted on the next cycle, in IDLE.
- ROUNDS=0 is illegal. Elaboration must fail it with a generate-time error or an $error.

## Timing
- Reset (resetn=0 at an edge) forces:
  - state=IDLE, work_reg=0, round_cnt=0, words_done=0.
  - Resulting outputs: in_ready=1, out_valid=0, busy=0, out_data=0.
- Reset mid-ROUND or mid-DONE aborts the word. It is never emitted, and words_done is not incremented.
- Latency: with the input accepted at edge t, out_valid rises after edge t+ROUNDS. There are exactly ROUNDS cycles in ROUND.
- Throughput with out_ready tied high: one word per ROUNDS+2 cycles.
- The round logic is one S-box LUT level plus a 2-input XOR per bit. It fits a single ICE_CLK cycle.
- words_done updates on the same edge that leaves DONE.
- busy rises on the accept edge and falls on the handoff edge.

## Test plan
- ROUNDS=1, default KEY: in_data=32'h00000000 -> after 1 ROUND cycle, out_valid=1 and out_data=32'hBDCEA3BD. Both handshakes complete and words_done=1.
- ROUNDS=2, KEY=0: in_data=32'h00000000 -> out_data=32'hFBFBFBFB (S(00)=63, S(63)=FB). Also check in_data=32'h52525252 with ROUNDS=1, KEY=0 -> out_data=0.
- Round trip at ROUNDS=4, default KEY: for 1000 LFSR words from seed 32'hACE1ACE1, a model encodes each word with four inverse-S-box rounds -> the decoded output equals the original LFSR word every time.
- Backpressure: hold out_ready=0 for 20 cycles in DONE while in_valid=1 with changing in_data -> out_data stays stable, in_ready=0, and the first word is emitted unchanged when out_ready rises.
- Reset mid-ROUND (pull resetn low at round 2 of 4) -> next cycle shows in_ready=1, out_valid=0, out_data=0, words_done unchanged at 0, and no word is emitted.
- Saturation: preload the counter via force, or stream 65 540 words -> words_done stays at 16'hFFFF and the datapath keeps operating.
